// File: rtl/grf_pkg.sv
// Shared definitions for the write-back register file and its trace FIFO.
// Trace entry layout (69 bits): {PC[68:37], A3[36:32], WD[31:0]}.
package grf_pkg;

  localparam int TRACE_DEPTH = 4;
  localparam int PTR_W       = 2;
  localparam int CNT_W       = 3;
  localparam int ENTRY_W     = 69;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  a3;
    logic [31:0] wd;
  } trace_entry_t;

  function automatic trace_entry_t make_entry(input logic [31:0] pc,
                                              input logic [4:0]  a3,
                                              input logic [31:0] wd);
    trace_entry_t e;
    e.pc = pc;
    e.a3 = a3;
    e.wd = wd;
    return e;
  endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Four-entry trace FIFO for committed register writes.
// Valid comes from registered occupancy only (no fall-through). A push into a
// full FIFO is accepted when a pop happens in the same cycle; otherwise it is
// dropped and the sticky overflow flag is raised.
module wb_trace_fifo
  import grf_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  trace_entry_t push_entry,
  input  logic         pop_ready,
  output logic         valid,
  output logic         full,
  output trace_entry_t head,
  output logic         overflow
);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  trace_entry_t     mem [TRACE_DEPTH];
  logic             pop;
  logic             push_ok;

  assign valid   = (count != '0);
  assign full    = (count == CNT_W'(TRACE_DEPTH));
  assign pop     = valid & pop_ready;
  assign push_ok = push & (~full | pop);
  assign head    = valid ? mem[rd_ptr] : '0;

  // Pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (push_ok && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !push_ok)
        count <= count - CNT_W'(1);
      if (push && !push_ok)
        overflow <= 1'b1;
    end
  end

  // Entry storage; contents are only visible through head while valid
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/wb_grf.sv
// Write-back stage general register file with commit trace and write counter.
// Optional macro WB_GRF_BYPASS_EN: when defined, reads of the register being
// written this cycle return WD_in instead of the pre-write array value.
module wb_grf
  import grf_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        RFWr_in,
  input  logic [4:0]  A3_in,
  input  logic [31:0] WD_in,
  input  logic [31:0] PC_in,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic        Trace_Valid,
  input  logic        Trace_Ready,
  output logic [31:0] Trace_PC,
  output logic [4:0]  Trace_A3,
  output logic [31:0] Trace_WD,
  output logic        Trace_Overflow,
  output logic [31:0] Write_Count
);

  logic [31:0]  regs [32];
  logic         commit;
  logic         fifo_full;
  trace_entry_t head;

  assign commit = RFWr_in && (A3_in != 5'd0);

  // Register array; entry 0 is never written and always reads as zero
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (commit) begin
      regs[A3_in] <= WD_in;
    end
  end

  // Committed write counter, wraps naturally at 32 bits
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      Write_Count <= '0;
    else if (commit)
      Write_Count <= Write_Count + 32'd1;
  end

  // Combinational read ports with optional same-cycle write bypass
  always_comb begin
    RD1 = (A1 == 5'd0) ? 32'd0 : regs[A1];
    RD2 = (A2 == 5'd0) ? 32'd0 : regs[A2];
`ifdef WB_GRF_BYPASS_EN
    if (commit && (A3_in == A1))
      RD1 = WD_in;
    if (commit && (A3_in == A2))
      RD2 = WD_in;
`endif
  end

  wb_trace_fifo u_trace_fifo (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .push       (commit),
    .push_entry (make_entry(PC_in, A3_in, WD_in)),
    .pop_ready  (Trace_Ready),
    .valid      (Trace_Valid),
    .full       (fifo_full),
    .head       (head),
    .overflow   (Trace_Overflow)
  );

  assign Trace_PC = head.pc;
  assign Trace_A3 = head.a3;
  assign Trace_WD = head.wd;

endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf: directed scenarios followed by random
// traffic, all compared against a queue/array reference model.
module tb_wb_grf;

  logic        Clk;
  logic        Rst_n;
  logic        RFWr_in;
  logic [4:0]  A3_in;
  logic [31:0] WD_in;
  logic [31:0] PC_in;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic        Trace_Valid;
  logic        Trace_Ready;
  logic [31:0] Trace_PC;
  logic [4:0]  Trace_A3;
  logic [31:0] Trace_WD;
  logic        Trace_Overflow;
  logic [31:0] Write_Count;

  wb_grf dut (
    .Clk            (Clk),
    .Rst_n          (Rst_n),
    .RFWr_in        (RFWr_in),
    .A3_in          (A3_in),
    .WD_in          (WD_in),
    .PC_in          (PC_in),
    .A1             (A1),
    .A2             (A2),
    .RD1            (RD1),
    .RD2            (RD2),
    .Trace_Valid    (Trace_Valid),
    .Trace_Ready    (Trace_Ready),
    .Trace_PC       (Trace_PC),
    .Trace_A3       (Trace_A3),
    .Trace_WD       (Trace_WD),
    .Trace_Overflow (Trace_Overflow),
    .Write_Count    (Write_Count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  a3;
    logic [31:0] wd;
  } ent_t;

  logic [31:0] m_regs [32];
  logic [31:0] m_wcount;
  logic        m_ovf;
  ent_t        m_q [$];

  int testsRun = 0;
  int testsFailed = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expRd(input logic [4:0] a, input logic we,
                                        input logic [4:0] a3, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
`ifdef WB_GRF_BYPASS_EN
    if (we && a3 == a) return wd;
`endif
    return m_regs[a];
  endfunction

  task automatic modelClear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_wcount = 32'd0;
    m_ovf = 1'b0;
    m_q.delete();
  endtask

  // Apply one clock edge worth of behaviour to the model
  task automatic modelEdge(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                           input logic [31:0] pc, input logic rdy);
    bit wasFull;
    bit doPop;
    ent_t e;
    wasFull = (m_q.size() == 4);
    doPop = (m_q.size() > 0) && rdy;
    if (doPop) void'(m_q.pop_front());
    if (we && a3 != 5'd0) begin
      m_regs[a3] = wd;
      m_wcount = m_wcount + 32'd1;
      if (!wasFull || doPop) begin
        e.pc = pc; e.a3 = a3; e.wd = wd;
        m_q.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic v;
    v = (m_q.size() > 0);
    check({tag, "_valid"}, {31'd0, Trace_Valid}, {31'd0, v});
    check({tag, "_pc"}, Trace_PC, v ? m_q[0].pc : 32'd0);
    check({tag, "_a3"}, {27'd0, Trace_A3}, v ? {27'd0, m_q[0].a3} : 32'd0);
    check({tag, "_wd"}, Trace_WD, v ? m_q[0].wd : 32'd0);
    check({tag, "_ovf"}, {31'd0, Trace_Overflow}, {31'd0, m_ovf});
    check({tag, "_wcount"}, Write_Count, m_wcount);
  endtask

  // Drive one cycle, check reads before the edge and trace state after it
  task automatic applyStimulus(input string tag, input logic we, input logic [4:0] a3,
                               input logic [31:0] wd, input logic [31:0] pc,
                               input logic [4:0] a1, input logic [4:0] a2, input logic rdy);
    RFWr_in = we; A3_in = a3; WD_in = wd; PC_in = pc;
    A1 = a1; A2 = a2; Trace_Ready = rdy;
    #1;
    check({tag, "_rd1"}, RD1, expRd(a1, we, a3, wd));
    check({tag, "_rd2"}, RD2, expRd(a2, we, a3, wd));
    @(posedge Clk);
    modelEdge(we, a3, wd, pc, rdy);
    #1;
    checkOutput(tag);
  endtask

  // Assert reset mid-cycle, check cleared state while held, then release
  task automatic doReset(input string tag);
    RFWr_in = 1'b0; Trace_Ready = 1'b0;
    Rst_n = 1'b0;
    modelClear();
    #1;
    checkOutput(tag);
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(31 - i);
      #1;
      check({tag, "_rd1_zero"}, RD1, 32'd0);
      check({tag, "_rd2_zero"}, RD2, 32'd0);
    end
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    checkOutput({tag, "_rel"});
  endtask

  // Pop everything with Trace_Ready=1; returns entry count and last A3 seen
  task automatic drain(input string tag, output int n, output logic [4:0] lastA3);
    n = 0;
    lastA3 = '0;
    for (int k = 0; k < 10; k++) begin
      if (!Trace_Valid) break;
      lastA3 = Trace_A3;
      n++;
      applyStimulus(tag, 1'b0, 5'd0, 32'd0, 32'd0, 5'd1, 5'd2, 1'b1);
    end
  endtask

  initial begin
    int n;
    logic [4:0] lastA3;
    logic [31:0] expSame;

    Rst_n = 1'b0; RFWr_in = 1'b0; A3_in = '0; WD_in = '0; PC_in = '0;
    A1 = '0; A2 = '0; Trace_Ready = 1'b0;
    modelClear();
    #3;
    checkOutput("reset");
    A1 = 5'd5;
    #1;
    check("reset_rd1", RD1, 32'd0);
    #3;
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // Write then read back
    applyStimulus("wr5", 1'b1, 5'd5, 32'h12345678, 32'h3000, 5'd5, 5'd0, 1'b0);
    check("wr5_head_pc", Trace_PC, 32'h3000);
    check("wr5_head_a3", {27'd0, Trace_A3}, 32'd5);
    check("wr5_head_wd", Trace_WD, 32'h12345678);
    check("wr5_count", Write_Count, 32'd1);
    applyStimulus("rd5", 1'b0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd0, 1'b0);
    check("rd5_value", RD1, 32'h12345678);

    // Write to $0 is ignored
    applyStimulus("wr0", 1'b1, 5'd0, 32'hFFFFFFFF, 32'h3004, 5'd0, 5'd0, 1'b0);
    check("wr0_count", Write_Count, 32'd1);
    check("wr0_rd1", RD1, 32'd0);

    // Same-cycle read during write
    applyStimulus("wr7a", 1'b1, 5'd7, 32'd1, 32'h3008, 5'd0, 5'd0, 1'b1);
`ifdef WB_GRF_BYPASS_EN
    expSame = 32'd2;
`else
    expSame = 32'd1;
`endif
    RFWr_in = 1'b1; A3_in = 5'd7; WD_in = 32'd2; PC_in = 32'h300C; A1 = 5'd7;
    #1;
    check("rdw_rd1", RD1, expSame);
    applyStimulus("wr7b", 1'b1, 5'd7, 32'd2, 32'h300C, 5'd7, 5'd7, 1'b1);

    // Overflow: five writes with no consumer
    doReset("rst1");
    for (int i = 1; i <= 5; i++)
      applyStimulus("ovf_wr", 1'b1, 5'(i), 32'hA000_0000 + 32'(i), 32'h4000 + 32'(4 * i),
                    5'd5, 5'd1, 1'b0);
    check("ovf_flag", {31'd0, Trace_Overflow}, 32'd1);
    check("ovf_head_a3", {27'd0, Trace_A3}, 32'd1);
    applyStimulus("ovf_rd5", 1'b0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd4, 1'b0);
    check("ovf_reg5", RD1, 32'hA000_0005);
    drain("ovf_drain", n, lastA3);
    check("ovf_occupancy", 32'(n), 32'd4);
    check("ovf_last_a3", {27'd0, lastA3}, 32'd4);
    check("ovf_sticky", {31'd0, Trace_Overflow}, 32'd1);

    // Full FIFO with simultaneous push and pop
    doReset("rst2");
    for (int i = 1; i <= 4; i++)
      applyStimulus("full_wr", 1'b1, 5'(10 + i), 32'hB000_0000 + 32'(i), 32'h5000 + 32'(i),
                    5'd11, 5'd12, 1'b0);
    applyStimulus("full_pp", 1'b1, 5'd9, 32'hCAFE_0009, 32'h5100, 5'd9, 5'd11, 1'b1);
    check("full_pp_ovf", {31'd0, Trace_Overflow}, 32'd0);
    check("full_pp_head_a3", {27'd0, Trace_A3}, 32'd12);
    drain("full_drain", n, lastA3);
    check("full_occupancy", 32'(n), 32'd4);
    check("full_last_a3", {27'd0, lastA3}, 32'd9);

    // Reset in the middle of a stream
    for (int i = 1; i <= 3; i++)
      applyStimulus("mid_wr", 1'b1, 5'(20 + i), 32'hD000_0000 + 32'(i), 32'h6000 + 32'(i),
                    5'd21, 5'd22, 1'b0);
    doReset("rst3");
    applyStimulus("post_rst_wr", 1'b1, 5'd3, 32'h0BAD_F00D, 32'h7000, 5'd3, 5'd0, 1'b0);
    check("post_rst_head_pc", Trace_PC, 32'h7000);
    check("post_rst_count", Write_Count, 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      applyStimulus("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                    $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 3) != 0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
